// File: rtl/fpu_normalize_round_pkg.sv
// Shared FPU constants: default datapath widths, result flag bit positions
// and the rounding-mode enumeration.
package fpu_normalize_round_pkg;

   localparam int FPU_WIDTH     = 106;
   localparam int FPU_WIDTH_LOG = 7;
   localparam int FPU_EXP_W     = 11;
   localparam int FPU_FRAC_W    = 52;

   // Flag vector layout is {overflow, underflow, inexact, zero}.
   localparam int FLAG_W         = 4;
   localparam int FLAG_OVERFLOW  = 3;
   localparam int FLAG_UNDERFLOW = 2;
   localparam int FLAG_INEXACT   = 1;
   localparam int FLAG_ZERO      = 0;

   typedef enum logic [2:0] {
      RM_RNE,
      RM_RTZ,
      RM_RDN,
      RM_RUP,
      RM_RMM
   } round_mode_e;

endpackage

// File: rtl/fpu_normalize_round_pri_encoder.sv
// Priority encoder returning the index of the most significant set bit;
// an all-zero input yields index 0, so callers must detect zero separately.
module fpu_pri_encoder #(
   parameter int WIDTH     = 106,
   parameter int WIDTH_LOG = 7
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [WIDTH_LOG-1:0] msb_o
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      msb_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_i[i]) begin
            msb_o = WIDTH_LOG'(i);
         end
      end
   end

endmodule

// File: rtl/fpu_normalize_round.sv
// Three-stage normalize / round-to-nearest-even / pack pipeline that turns a
// raw mantissa product into a packed IEEE-754 result with status flags.
module fpu_normalize_round
   import fpu_normalize_round_pkg::*;
#(
   parameter int WIDTH     = FPU_WIDTH,
   parameter int WIDTH_LOG = FPU_WIDTH_LOG,
   parameter int EXP_W     = FPU_EXP_W,
   parameter int FRAC_W    = FPU_FRAC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sign,
   input  logic [EXP_W+2:0]   in_exp,
   input  logic [WIDTH-1:0]   in_mant,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sign,
   output logic [EXP_W-1:0]   out_exp,
   output logic [FRAC_W-1:0]  out_frac,
   output logic [FLAG_W-1:0]  out_flags
);

   localparam int EW = EXP_W + 3;
   localparam logic [EW-1:0]        EXP_REF    = EW'(WIDTH - 2);
   localparam logic [EW-1:0]        EXP_MAX    = EW'((1 << EXP_W) - 1);
   localparam logic [EW-1:0]        EXP_ZERO   = '0;
   localparam logic [WIDTH_LOG-1:0] TOP_IDX    = WIDTH_LOG'(WIDTH - 1);
   localparam round_mode_e          ROUND_MODE = RM_RNE;

   logic                 s1Ready;
   logic                 s2Ready;
   logic                 s3Ready;

   logic                 s1Valid_q;
   logic                 s2Valid_q;
   logic                 s3Valid_q;

   logic [WIDTH_LOG-1:0] leadIdx;
   logic                 s1Sign_q;
   logic [EW-1:0]        s1Exp_q;
   logic [WIDTH-1:0]     s1Mant_q;
   logic [WIDTH_LOG-1:0] s1Idx_q;

   logic [WIDTH_LOG-1:0] shiftAmt;
   logic [WIDTH-1:0]     mantNorm_d;
   logic [EW-1:0]        expAdj_d;

   logic                 s2Sign_q;
   logic [EW-1:0]        s2Exp_q;
   logic [WIDTH-2:0]     s2Mant_q;
   logic                 s2Zero_q;

   logic [FRAC_W-1:0]    fracRaw;
   logic                 guardBit;
   logic                 stickyBit;
   logic [FRAC_W:0]      fracInc;
   logic                 roundUp;
   logic                 fracCarry;
   logic [FRAC_W-1:0]    fracRnd;
   logic [EW-1:0]        expRnd;
   logic                 isOverflow;
   logic                 isUnderflow;

   logic                 outSign_d;
   logic [EXP_W-1:0]     outExp_d;
   logic [FRAC_W-1:0]    outFrac_d;
   logic [FLAG_W-1:0]    outFlags_d;

   logic                 outSign_q;
   logic [EXP_W-1:0]     outExp_q;
   logic [FRAC_W-1:0]    outFrac_q;
   logic [FLAG_W-1:0]    outFlags_q;

   // A stage may load whenever it is empty or its content moves on this cycle.
   assign s3Ready  = !s3Valid_q || out_ready;
   assign s2Ready  = !s2Valid_q || s3Ready;
   assign s1Ready  = !s1Valid_q || s2Ready;
   assign in_ready = s1Ready;

   fpu_pri_encoder #(
      .WIDTH     (WIDTH),
      .WIDTH_LOG (WIDTH_LOG)
   ) uPriEnc (
      .in_i  (in_mant),
      .msb_o (leadIdx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s2Valid_q <= 1'b0;
         s3Valid_q <= 1'b0;
      end else begin
         if (s1Ready) s1Valid_q <= in_valid;
         if (s2Ready) s2Valid_q <= s1Valid_q;
         if (s3Ready) s3Valid_q <= s2Valid_q;
      end
   end

   // Move the leading one to bit WIDTH-1 and rebase the exponent to match.
   always_comb begin
      shiftAmt   = TOP_IDX - s1Idx_q;
      mantNorm_d = s1Mant_q << shiftAmt;
      expAdj_d   = s1Exp_q + {{(EW-WIDTH_LOG){1'b0}}, s1Idx_q} - EXP_REF;
   end

   // A zero mantissa is the only input that leaves no leading one after the shift.
   always_ff @(posedge clk) begin
      if (in_valid && s1Ready) begin
         s1Sign_q <= in_sign;
         s1Exp_q  <= in_exp;
         s1Mant_q <= in_mant;
         s1Idx_q  <= leadIdx;
      end
      if (s1Valid_q && s2Ready) begin
         s2Sign_q <= s1Sign_q;
         s2Exp_q  <= expAdj_d;
         s2Mant_q <= mantNorm_d[WIDTH-2:0];
         s2Zero_q <= !mantNorm_d[WIDTH-1];
      end
   end

   always_comb begin
      fracRaw     = s2Mant_q[WIDTH-2 -: FRAC_W];
      guardBit    = s2Mant_q[WIDTH-2-FRAC_W];
      stickyBit   = |s2Mant_q[WIDTH-3-FRAC_W:0];
      fracInc     = {1'b0, fracRaw} + (FRAC_W+1)'(1);
      roundUp     = (ROUND_MODE == RM_RNE) && guardBit && (stickyBit || fracRaw[0]);
      fracCarry   = roundUp && fracInc[FRAC_W];
      fracRnd     = roundUp ? fracInc[FRAC_W-1:0] : fracRaw;
      expRnd      = s2Exp_q + EW'(fracCarry);
      isOverflow  = !s2Zero_q && ($signed(expRnd) >= $signed(EXP_MAX));
      isUnderflow = !s2Zero_q && ($signed(expRnd) <= $signed(EXP_ZERO));
   end

   // Special cases replace the rounded value; inexact reflects the discarded bits
   // except that overflow and underflow always report it.
   always_comb begin
      outSign_d  = s2Sign_q;
      outExp_d   = expRnd[EXP_W-1:0];
      outFrac_d  = fracRnd;
      outFlags_d = '0;
      if (s2Zero_q) begin
         outExp_d              = '0;
         outFrac_d             = '0;
         outFlags_d[FLAG_ZERO] = 1'b1;
      end else if (isOverflow) begin
         outExp_d                  = '1;
         outFrac_d                 = '0;
         outFlags_d[FLAG_OVERFLOW] = 1'b1;
         outFlags_d[FLAG_INEXACT]  = 1'b1;
      end else if (isUnderflow) begin
         outExp_d                   = '0;
         outFrac_d                  = '0;
         outFlags_d[FLAG_UNDERFLOW] = 1'b1;
         outFlags_d[FLAG_INEXACT]   = 1'b1;
      end else begin
         outFlags_d[FLAG_INEXACT] = guardBit || stickyBit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outSign_q  <= 1'b0;
         outExp_q   <= '0;
         outFrac_q  <= '0;
         outFlags_q <= '0;
      end else if (s3Ready && s2Valid_q) begin
         outSign_q  <= outSign_d;
         outExp_q   <= outExp_d;
         outFrac_q  <= outFrac_d;
         outFlags_q <= outFlags_d;
      end
   end

   assign out_valid = s3Valid_q;
   assign out_sign  = outSign_q;
   assign out_exp   = outExp_q;
   assign out_frac  = outFrac_q;
   assign out_flags = outFlags_q;

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed and randomized bench for fpu_normalize_round, scoring every output
// against an arithmetic reference model or hand-computed constants.
module tb_fpu_normalize_round;

   localparam int WIDTH     = 106;
   localparam int WIDTH_LOG = 7;
   localparam int EXP_W     = 11;
   localparam int FRAC_W    = 52;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               in_sign = 1'b0;
   logic [EXP_W+2:0]   in_exp = '0;
   logic [WIDTH-1:0]   in_mant = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic               out_sign;
   logic [EXP_W-1:0]   out_exp;
   logic [FRAC_W-1:0]  out_frac;
   logic [3:0]         out_flags;

   typedef struct {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
      logic [3:0]        flags;
      int                acceptCycle;
      bit                checkLat;
   } result_t;

   result_t expQ[$];
   int      checks = 0;
   int      errors = 0;
   int      cycle = 0;

   fpu_normalize_round #(
      .WIDTH     (WIDTH),
      .WIDTH_LOG (WIDTH_LOG),
      .EXP_W     (EXP_W),
      .FRAC_W    (FRAC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_frac  (out_frac),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic result_t mk(input logic s, input int e, input longint f, input logic [3:0] fl);
      result_t r;
      r.sign        = s;
      r.exp         = EXP_W'(e);
      r.frac        = FRAC_W'(f);
      r.flags       = fl;
      r.acceptCycle = 0;
      r.checkLat    = 1'b1;
      return r;
   endfunction

   // Real-valued view: keep 53 significant bits with round-half-even, then classify.
   function automatic result_t refModel(input logic s, input logic [EXP_W+2:0] e, input logic [WIDTH-1:0] mant);
      result_t      r;
      logic [106:0] t, q, rem, half;
      int           m, ex;
      bit           inexact;
      r = mk(s, 0, 0, 4'b0001);
      r.checkLat = 1'b0;
      if (mant == '0) return r;
      m = -1;
      t = {1'b0, mant};
      while (t != 0) begin
         t = t >> 1;
         m++;
      end
      inexact = 1'b0;
      if (m > 52) begin
         q    = {1'b0, mant} >> (m - 52);
         rem  = {1'b0, mant} - (q << (m - 52));
         half = 107'd1 << (m - 53);
         if (rem != 0) inexact = 1'b1;
         if (rem > half || (rem == half && q[0])) q = q + 1;
      end else begin
         q = {1'b0, mant} << (52 - m);
      end
      ex = int'($signed(e)) + m - 104;
      if (q == (107'd1 << 53)) begin
         q = q >> 1;
         ex++;
      end
      if (ex >= 2047) begin
         r.exp = '1; r.frac = '0; r.flags = 4'b1010;
      end else if (ex <= 0) begin
         r.exp = '0; r.frac = '0; r.flags = 4'b0110;
      end else begin
         r.exp = EXP_W'(ex); r.frac = q[51:0]; r.flags = {2'b00, inexact, 1'b0};
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] randMant();
      logic [127:0]     r;
      logic [WIDTH-1:0] m;
      r = {$urandom, $urandom, $urandom, $urandom};
      m = r[WIDTH-1:0] >> $urandom_range(0, WIDTH-1);
      if ($urandom_range(0, 3) == 0) m = m & ({WIDTH{1'b1}} << $urandom_range(0, 60));
      if ($urandom_range(0, 19) == 0) m = '0;
      return m;
   endfunction

   function automatic logic [EXP_W+2:0] randExp();
      int x;
      x = int'($urandom_range(0, 2300)) - 100;
      return (EXP_W+3)'(x);
   endfunction

   task automatic checkOutput();
      result_t f;
      if (expQ.size() == 0) begin
         check("spuriousOutput", out_valid, 1'b0);
         return;
      end
      f = expQ[0];
      check("sign", out_sign, f.sign);
      check("exp", out_exp, f.exp);
      check("frac", out_frac, f.frac);
      check("flags", out_flags, f.flags);
      if (out_ready) begin
         if (f.checkLat) check("latency", cycle - f.acceptCycle, 3);
         void'(expQ.pop_front());
      end
   endtask

   task automatic applyStimulus(input logic vld, input logic sgn, input logic [EXP_W+2:0] e,
                                input logic [WIDTH-1:0] mant, input logic ordy, input bit useModel,
                                input result_t dir, output bit acc);
      result_t r;
      @(negedge clk);
      in_valid  = vld;
      in_sign   = sgn;
      in_exp    = e;
      in_mant   = mant;
      out_ready = ordy;
      #1;
      cycle++;
      if (out_valid) checkOutput();
      acc = vld && in_ready;
      if (acc) begin
         r = useModel ? refModel(sgn, e, mant) : dir;
         r.acceptCycle = cycle;
         expQ.push_back(r);
      end
   endtask

   task automatic idle(input logic ordy);
      result_t d;
      bit      acc;
      d = mk(0, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, '0, '0, ordy, 1'b1, d, acc);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1'b1);
      check("drainEmpty", expQ.size(), 0);
   endtask

   task automatic runDirected(input logic sgn, input logic [EXP_W+2:0] e, input logic [WIDTH-1:0] mant,
                              input result_t want);
      bit acc;
      applyStimulus(1'b1, sgn, e, mant, 1'b1, 1'b0, want, acc);
      check("directedAccept", acc, 1'b1);
      drain();
   endtask

   initial begin
      logic [WIDTH-1:0]   v;
      logic [WIDTH-1:0]   stallMant[4];
      logic [EXP_W+2:0]   stallExp[4];
      logic               pS;
      logic [EXP_W+2:0]   pE;
      logic [WIDTH-1:0]   pM;
      bit                 pending;
      bit                 acc;
      int                 idx;
      result_t            d;

      d = mk(0, 0, 0, 0);
      #12;
      check("resetValid", out_valid, 1'b0);
      check("resetSign", out_sign, 1'b0);
      check("resetExp", out_exp, 0);
      check("resetFrac", out_frac, 0);
      check("resetFlags", out_flags, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("resetInReady", in_ready, 1'b1);

      v = '0; v[104] = 1'b1;
      runDirected(1'b0, 14'd1023, v, mk(0, 1023, 0, 4'b0000));
      v = '0; v[105] = 1'b1; v[52] = 1'b1;
      runDirected(1'b0, 14'd1023, v, mk(0, 1024, 0, 4'b0010));
      v[53] = 1'b1;
      runDirected(1'b0, 14'd1023, v, mk(0, 1024, 2, 4'b0010));
      v = '1;
      runDirected(1'b1, 14'd1023, v, mk(1, 1025, 0, 4'b0010));
      v = '0; v[105] = 1'b1;
      runDirected(1'b0, 14'd2046, v, mk(0, 2047, 0, 4'b1010));
      v = '0; v[104] = 1'b1;
      runDirected(1'b0, 14'd0, v, mk(0, 0, 0, 4'b0110));
      runDirected(1'b0, 14'd2046, v, mk(0, 2046, 0, 4'b0000));
      runDirected(1'b0, 14'd1, v, mk(0, 1, 0, 4'b0000));
      v = '0;
      runDirected(1'b1, 14'd500, v, mk(1, 0, 0, 4'b0001));

      pending = 1'b0;
      pS = 1'b0; pE = '0; pM = '0;
      for (int c = 0; c < 300; c++) begin
         if (!pending) begin
            pending = ($urandom_range(0, 3) != 0);
            pS = 1'($urandom_range(0, 1));
            pE = randExp();
            pM = randMant();
         end
         applyStimulus(pending, pS, pE, pM, ($urandom_range(0, 9) < 7), 1'b1, d, acc);
         if (acc) pending = 1'b0;
      end
      drain();

      for (int i = 0; i < 4; i++) begin
         stallMant[i] = randMant() | (WIDTH'(1) << (100 + i));
         stallExp[i]  = 14'(900 + 37 * i);
      end
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, stallExp[idx], stallMant[idx], 1'b0, 1'b1, d, acc);
         if (acc) idx++;
      end
      check("stallAccepted", idx, 3);
      check("stallInReady", in_ready, 1'b0);
      for (int c = 0; c < 10 && idx < 4; c++) begin
         applyStimulus(1'b1, 1'b0, stallExp[idx], stallMant[idx], 1'b1, 1'b1, d, acc);
         if (acc) idx++;
      end
      check("stallAllAccepted", idx, 4);
      drain();

      applyStimulus(1'b1, 1'b0, 14'd1000, randMant() | (WIDTH'(1) << 105), 1'b0, 1'b1, d, acc);
      applyStimulus(1'b1, 1'b1, 14'd1100, randMant() | (WIDTH'(1) << 103), 1'b0, 1'b1, d, acc);
      idle(1'b0);
      @(posedge clk);
      #2;
      check("preResetValid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("asyncResetValid", out_valid, 1'b0);
      check("asyncResetFlags", out_flags, 0);
      expQ.delete();
      #4;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         idle(1'b1);
         check("postResetIdle", out_valid, 1'b0);
         check("postResetInReady", in_ready, 1'b1);
      end
      v = '0; v[104] = 1'b1;
      runDirected(1'b1, 14'd1023, v, mk(1, 1023, 0, 4'b0000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
